// File: rtl/if0_pc_gen.sv
// if0_pc_gen: fetch PC generator (redirects, next-line prediction, MIPS delay-slot handling); prediction enabled by IF0_NLP_PREDICT_EN.
module if0_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if1_ready,
  input  logic        backend_redir_valid,
  input  logic [31:0] backend_redir_target,
  input  logic        if3_redir_valid,
  input  logic [31:0] if3_redir_target,
  input  logic        nlp_valid0,
  input  logic        nlp_taken0,
  input  logic [31:0] nlp_target0,
  input  logic [1:0]  nlp_bim0,
  input  logic        nlp_valid1,
  input  logic        nlp_taken1,
  input  logic [31:0] nlp_target1,
  input  logic [1:0]  nlp_bim1,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic [1:0]  fetch_mask,
  output logic [1:0]  pred_taken,
  output logic [31:0] pred_target,
  output logic [1:0]  pred_bim0,
  output logic [1:0]  pred_bim1
);
  typedef enum logic {RUN, DS_PENDING} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt_q, tgt_d, seq_pc;
  logic        fv_q, fv_d, hit0, hit1;
  assign pc          = pc_q;
  assign fetch_valid = fv_q;
  assign fetch_mask  = state_q == DS_PENDING ? 2'b01 : pc_q[2] ? 2'b10 : 2'b11;
  assign seq_pc      = {pc_q[31:3] + 29'd1, 3'b000};
  assign pred_taken  = {hit1, hit0};
`ifdef IF0_NLP_PREDICT_EN
  // hit1 is a last-slot hit: slot1 of a full group, or the lone slot of an odd-word group
  assign hit0 = fv_q && state_q == RUN && !pc_q[2] && nlp_valid0 && nlp_taken0;
  assign hit1 = fv_q && state_q == RUN && !hit0 &&
                (pc_q[2] ? nlp_valid0 && nlp_taken0 : nlp_valid1 && nlp_taken1);
  assign pred_target = hit0 || (hit1 && pc_q[2]) ? nlp_target0 : hit1 ? nlp_target1 : '0;
  assign pred_bim0   = fv_q && fetch_mask[0] ? nlp_bim0 : '0;
  assign pred_bim1   = fv_q && fetch_mask[1] ? (pc_q[2] ? nlp_bim0 : nlp_bim1) : '0;
`else
  logic unused_nlp;
  assign unused_nlp  = ^{nlp_valid0, nlp_taken0, nlp_target0, nlp_bim0,
                         nlp_valid1, nlp_taken1, nlp_target1, nlp_bim1};
  assign hit0        = 1'b0;
  assign hit1        = 1'b0;
  assign pred_target = '0;
  assign pred_bim0   = '0;
  assign pred_bim1   = '0;
`endif
  always_comb begin
    pc_d    = pc_q;
    fv_d    = fv_q;
    state_d = state_q;
    tgt_d   = tgt_q;
    if (backend_redir_valid) begin
      pc_d    = backend_redir_target;
      fv_d    = 1'b1;
      state_d = RUN;
      tgt_d   = '0;
    end else if (flush) begin
      fv_d = 1'b0;
    end else if (if3_redir_valid) begin
      pc_d    = if3_redir_target;
      fv_d    = 1'b1;
      state_d = RUN;
      tgt_d   = '0;
    end else if (!fv_q) begin
      fv_d = 1'b1;
    end else if (if1_ready) begin
      if (state_q == DS_PENDING) begin
        pc_d    = tgt_q;
        state_d = RUN;
        tgt_d   = '0;
      end else if (hit0) begin
        pc_d = nlp_target0;
      end else if (hit1) begin
        pc_d    = seq_pc;
        state_d = DS_PENDING;
        tgt_d   = pred_target;
      end else begin
        pc_d = seq_pc;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      fv_q    <= 1'b0;
      state_q <= RUN;
      tgt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      fv_q    <= fv_d;
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end
endmodule

// File: tb/tb_if0_pc_gen.sv
// tb_if0_pc_gen: directed vector table plus randomized run against a slot-level reference model of if0_pc_gen.
module tb_if0_pc_gen;
`ifdef IF0_NLP_PREDICT_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  logic clk = 0, rst = 1, flush = 0, if1_ready = 0, brv = 0, irv = 0;
  logic [31:0] bt = 0, it = 0, g0 = 0, g1 = 0;
  logic v0 = 0, t0 = 0, v1 = 0, t1 = 0;
  logic [1:0] bm0 = 0, bm1 = 0;
  logic [31:0] pc, pred_target;
  logic fetch_valid;
  logic [1:0] fetch_mask, pred_taken, pred_bim0, pred_bim1;
  int total = 0, bad = 0;
  bit [31:0] m_pc;
  bit m_fv;
  bit [31:0] m_ds[$];

  if0_pc_gen dut (
    .clk(clk), .rst(rst), .flush(flush), .if1_ready(if1_ready),
    .backend_redir_valid(brv), .backend_redir_target(bt),
    .if3_redir_valid(irv), .if3_redir_target(it),
    .nlp_valid0(v0), .nlp_taken0(t0), .nlp_target0(g0), .nlp_bim0(bm0),
    .nlp_valid1(v1), .nlp_taken1(t1), .nlp_target1(g1), .nlp_bim1(bm1),
    .pc(pc), .fetch_valid(fetch_valid), .fetch_mask(fetch_mask),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_bim0(pred_bim0), .pred_bim1(pred_bim1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit brv; bit [31:0] bt; bit irv; bit [31:0] it; bit fl; bit rdy;
    bit v0, t0; bit [31:0] g0; bit v1, t1; bit [31:0] g1;
    bit [31:0] e_pc; bit e_fv; bit [1:0] e_mask, e_pt; bit [31:0] e_tg;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    m_fv = 0;
    m_ds.delete();
  endtask

  // Slot s of the 8-byte group holds word base+4s, which is predictor entry s - pc[2]
  task automatic model_out(output bit [1:0] m, output bit [1:0] pt, output bit [31:0] tg,
                           output bit [1:0] b0, output bit [1:0] b1);
    bit v[2], t[2], live, got;
    bit [31:0] g[2];
    bit [1:0] bm[2];
    v = '{v0, v1}; t = '{t0, t1}; g = '{g0, g1}; bm = '{bm0, bm1};
    live = PE && m_fv && m_ds.size() == 0;
    m = m_ds.size() != 0 ? 2'b01 : (m_pc[2] ? 2'b10 : 2'b11);
    pt = 0; tg = 0; b0 = 0; b1 = 0; got = 0;
    for (int s = 0; s < 2; s++) begin
      int k;
      k = s - int'(m_pc[2]);
      if (m[s] && k >= 0) begin
        if (PE && m_fv) begin
          if (s == 0) b0 = bm[k]; else b1 = bm[k];
        end
        if (live && !got && v[k] && t[k]) begin
          pt[s] = 1; tg = g[k]; got = 1;
        end
      end
    end
  endtask

  task automatic step();
    bit [1:0] m, pt, b0, b1;
    bit [31:0] tg, seq;
    #1;
    model_out(m, pt, tg, b0, b1);
    chk("pc", pc, m_pc);
    chk("fetch_valid", 32'(fetch_valid), 32'(m_fv));
    chk("fetch_mask", 32'(fetch_mask), 32'(m));
    chk("pred_taken", 32'(pred_taken), 32'(pt));
    chk("pred_target", pred_target, tg);
    chk("pred_bim0", 32'(pred_bim0), 32'(b0));
    chk("pred_bim1", 32'(pred_bim1), 32'(b1));
    seq = (m_pc & ~32'h7) + 32'd8;
    if (brv) begin m_pc = bt; m_fv = 1; m_ds.delete(); end
    else if (flush) m_fv = 0;
    else if (irv) begin m_pc = it; m_fv = 1; m_ds.delete(); end
    else if (!m_fv) m_fv = 1;
    else if (if1_ready) begin
      if (m_ds.size() != 0) m_pc = m_ds.pop_front();
      else if (pt[1]) begin m_ds.push_back(tg); m_pc = seq; end
      else if (pt[0]) m_pc = tg;
      else m_pc = seq;
    end
    @(negedge clk);
  endtask

  task automatic drive(input vec_t r);
    brv = r.brv; bt = r.bt; irv = r.irv; it = r.it; flush = r.fl; if1_ready = r.rdy;
    v0 = r.v0; t0 = r.t0; g0 = r.g0; v1 = r.v1; t1 = r.t1; g1 = r.g1;
  endtask

  function automatic vec_t row(bit brv_, bit [31:0] bt_, bit irv_, bit [31:0] it_, bit fl, bit rdy,
                               bit v0_, bit t0_, bit [31:0] g0_, bit v1_, bit t1_, bit [31:0] g1_,
                               bit [31:0] epc, bit efv, bit [1:0] em, bit [1:0] ept, bit [31:0] etg);
    return '{brv_, bt_, irv_, it_, fl, rdy, v0_, t0_, g0_, v1_, t1_, g1_, epc, efv, em, ept, etg};
  endfunction

  initial begin
    // columns: brv bt irv it flush rdy | v0 t0 g0 v1 t1 g1 | exp pc fv mask ptaken ptarget
    tbl.push_back(row(0,0,0,0,0,1, 0,0,0,0,0,0, 32'hBFC00000,0,2'b11,2'b00,0));
    tbl.push_back(row(0,0,0,0,0,1, 0,0,0,0,0,0, 32'hBFC00000,1,2'b11,2'b00,0));
    tbl.push_back(row(0,0,0,0,0,1, 0,0,0,0,0,0, 32'hBFC00008,1,2'b11,2'b00,0));
    tbl.push_back(row(1,32'h9000,1,32'hA000,0,1, 0,0,0,0,0,0, 32'hBFC00010,1,2'b11,2'b00,0));
    tbl.push_back(row(0,0,1,32'h80000000,0,1, 0,0,0,0,0,0, 32'h00009000,1,2'b11,2'b00,0));
    tbl.push_back(row(0,0,0,0,0,1, 1,1,32'h80001000,0,0,0, 32'h80000000,1,2'b11,
                      PE ? 2'b01 : 2'b00, PE ? 32'h80001000 : 0));
    if (PE) begin
      tbl.push_back(row(0,0,1,32'h80000000,0,1, 0,0,0,0,0,0, 32'h80001000,1,2'b11,2'b00,0));
      tbl.push_back(row(0,0,0,0,0,1, 1,0,32'h80009000,1,1,32'h80002000, 32'h80000000,1,2'b11,2'b10,32'h80002000));
      for (int i = 0; i < 3; i++)
        tbl.push_back(row(0,0,0,0,0,0, 1,1,32'h80007000,0,0,0, 32'h80000008,1,2'b01,2'b00,0));
      tbl.push_back(row(0,0,1,32'h80003000,0,0, 0,0,0,0,0,0, 32'h80000008,1,2'b01,2'b00,0));
      tbl.push_back(row(0,0,0,0,0,1, 0,0,0,0,0,0, 32'h80003000,1,2'b11,2'b00,0));
      tbl.push_back(row(0,0,1,32'h80000004,0,1, 0,0,0,0,0,0, 32'h80003008,1,2'b11,2'b00,0));
      tbl.push_back(row(0,0,0,0,0,1, 1,1,32'h80004000,0,0,0, 32'h80000004,1,2'b10,2'b10,32'h80004000));
      tbl.push_back(row(0,0,0,0,0,1, 1,1,32'h80005000,0,0,0, 32'h80000008,1,2'b01,2'b00,0));
      tbl.push_back(row(0,0,0,0,0,1, 0,0,0,0,0,0, 32'h80004000,1,2'b11,2'b00,0));
      tbl.push_back(row(0,0,0,0,1,1, 0,0,0,0,0,0, 32'h80004008,1,2'b11,2'b00,0));
      tbl.push_back(row(0,0,0,0,0,1, 0,0,0,0,0,0, 32'h80004008,0,2'b11,2'b00,0));
      tbl.push_back(row(0,0,0,0,0,1, 0,0,0,0,0,0, 32'h80004008,1,2'b11,2'b00,0));
      tbl.push_back(row(1,32'hFFFFFFF8,0,0,1,1, 0,0,0,0,0,0, 32'h80004010,1,2'b11,2'b00,0));
    end else begin
      tbl.push_back(row(0,0,1,32'h80000004,0,1, 1,1,32'h80001000,0,0,0, 32'h80000008,1,2'b11,2'b00,0));
      tbl.push_back(row(0,0,0,0,0,1, 1,1,32'h80004000,0,0,0, 32'h80000004,1,2'b10,2'b00,0));
      tbl.push_back(row(0,0,0,0,1,1, 0,0,0,0,0,0, 32'h80000008,1,2'b11,2'b00,0));
      tbl.push_back(row(0,0,0,0,0,1, 0,0,0,0,0,0, 32'h80000008,0,2'b11,2'b00,0));
      tbl.push_back(row(0,0,0,0,0,1, 0,0,0,0,0,0, 32'h80000008,1,2'b11,2'b00,0));
      tbl.push_back(row(1,32'hFFFFFFF8,0,0,1,1, 0,0,0,0,0,0, 32'h80000010,1,2'b11,2'b00,0));
    end
    tbl.push_back(row(0,0,0,0,0,1, 0,0,0,0,0,0, 32'hFFFFFFF8,1,2'b11,2'b00,0));
    tbl.push_back(row(0,0,0,0,0,1, 0,0,0,0,0,0, 32'h00000000,1,2'b11,2'b00,0));

    v0 = 1; t0 = 1; g0 = 32'h1234; bm0 = 2'b11; bm1 = 2'b10;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_fetch_valid", 32'(fetch_valid), 0);
    chk("rst_fetch_mask", 32'(fetch_mask), 32'h3);
    chk("rst_pred_taken", 32'(pred_taken), 0);
    chk("rst_pred_target", pred_target, 0);
    chk("rst_pred_bim", 32'({pred_bim1, pred_bim0}), 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    bm0 = 2'b01; bm1 = 2'b10;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("row%0d_fv", i), 32'(fetch_valid), 32'(tbl[i].e_fv));
      chk($sformatf("row%0d_mask", i), 32'(fetch_mask), 32'(tbl[i].e_mask));
      chk($sformatf("row%0d_ptaken", i), 32'(pred_taken), 32'(tbl[i].e_pt));
      chk($sformatf("row%0d_ptarget", i), pred_target, tbl[i].e_tg);
      step();
    end

    for (int n = 0; n < 2000; n++) begin
      brv = $urandom_range(15) == 0;
      bt = $urandom_range(3) == 0 ? 32'hFFFFFFF0 | ($urandom & 32'hC) : $urandom & ~32'h3;
      flush = brv ? $urandom_range(1) == 0 : $urandom_range(31) == 0;
      irv = $urandom_range(9) == 0;
      it = $urandom & ~32'h3;
      if1_ready = $urandom_range(3) != 0;
      v0 = $urandom_range(1); t0 = $urandom_range(1); g0 = $urandom & ~32'h3;
      v1 = $urandom_range(1); t1 = $urandom_range(1); g1 = $urandom & ~32'h3;
      bm0 = 2'($urandom); bm1 = 2'($urandom);
      step();
    end

    // asynchronous reset landing in the middle of a stall
    drive(row(1,32'h12345670,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0));
    step();
    brv = 0;
    repeat (2) step();
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_pc", pc, RST_PC);
    chk("async_rst_fetch_valid", 32'(fetch_valid), 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    if1_ready = 1;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if0_pc_gen.md
# if0_pc_gen

Fetch-stage-0 PC generator. Holds the fetch PC, drives it to the next-line predictor and instruction fetch, and picks the next fetch PC from backend redirects, IF3 redirects, next-line predictions and sequential increment. Sits directly upstream of the next-line predictor, which it addresses, and consumes the predictor's per-slot prediction output in the same cycle. Handles MIPS delay slots when a taken prediction falls on the last slot of a fetch group.

## Interface
- RESET_PC, 32'hBFC0_0000, fetch PC loaded on reset
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush; accompanies a backend redirect, squashes the current fetch
- if1_ready  in  1  IF1 accepts the current fetch group this cycle
- backend_redir_valid / backend_redir_target  in  1 / 32  mispredict or exception redirect
- if3_redir_valid / if3_redir_target  in  1 / 32  IF3 decode-time correction
- nlp_valid0, nlp_taken0, nlp_target0, nlp_bim0  in  1,1,32,2  prediction for PC
- nlp_valid1, nlp_taken1, nlp_target1, nlp_bim1  in  1,1,32,2  prediction for PC+4
- pc  out  32  current fetch PC; also the predictor lookup address
- fetch_valid  out  1  fetch group valid
- fetch_mask  out  2  slot enables; bit0 = 8-byte-aligned low word, bit1 = high word
- pred_taken  out  2  per-slot taken prediction passed to IF1
- pred_target  out  32  predicted target of the taken slot
- pred_bim0, pred_bim1  out  2 each  per-slot bimodal state, for later predictor update

## Operation
- Group: 8-byte aligned. pc[2]=0 gives mask 2'b11. pc[2]=1 gives mask 2'b10. Sequential next PC = {pc[31:3]+1, 3'b000}.
- Prediction hit means valid && taken.
  - pc[2]=0: slot0 hit wins over slot1.
  - pc[2]=1: only nlp_*0 applies, to slot1.
- Slot0 hit: next PC = nlp_target0. The delay slot (slot1) is in the same group. Mask stays 2'b11.
- Last-slot hit (slot1 when pc[2]=0, or the pc[2]=1 case): target latched, FSM enters DS_PENDING, next PC = sequential.
- FSM states:
  - RUN: normal operation as above.
  - DS_PENDING: group is fetched with mask 2'b01 (delay slot only) and pred_taken=0. On accept, next PC = latched target and FSM returns to RUN.
- Next-PC priority, highest first:
  1. backend_redir_valid (with or without flush)
  2. if3_redir_valid
  3. DS_PENDING latched target
  4. prediction
  5. sequential
- Any redirect loads the target into pc the next edge, regardless of if1_ready, and forces the FSM to RUN, discarding any latched target.
- pred_taken: one-hot for the hit slot, or 0. pred_target is 0 when pred_taken=0.
- Stall (fetch_valid && !if1_ready): pc, FSM, mask and latched target hold. Prediction inputs are re-evaluated each cycle from the unchanged pc.

## Timing
- Reset (async) values: pc=RESET_PC, fetch_valid=0, fetch_mask=2'b11, pred_taken=0, pred_target=0, pred_bim0=0, pred_bim1=0, FSM=RUN, latched target=0.
- First clk edge after rst deasserts sets fetch_valid=1 with pc=RESET_PC.
- Prediction-to-pc latency: 1 cycle. Outputs pred_* are combinational from the nlp inputs and pc.
- Redirect latency: 1 cycle. A redirect on cycle N gives pc=target and fetch_valid=1 on N+1.
- flush without a backend redirect: fetch_valid=0 next cycle, pc holds. fetch_valid returns to 1 the following cycle.
- Redirect while in DS_PENDING and stalled: the redirect wins and the delay slot is not fetched here (the backend or IF3 owns its replay).
- The pc increment wraps modulo 2^32 with no trap.

## Configuration
- IF0_NLP_PREDICT_EN.
  - Defined: prediction and DS_PENDING behaviour as above.
  - Undefined: nlp inputs are ignored; pred_taken=0, pred_target=0, pred_bim0=pred_bim1=0; FSM stays in RUN. Next PC is redirect or sequential only.

## Test plan
- Reset, then release with if1_ready=1 and no predictions: pc sequence BFC00000, BFC00008, BFC00010; mask 11 each cycle.
- pc=0x80000000, nlp slot0 valid/taken target 0x80001000: pred_taken=01, mask 11, next pc=0x80001000.
- pc=0x80000000, slot1 taken target 0x80002000: next pc=0x80000008 with mask 01 and pred_taken=00, then pc=0x80002000.
- In DS_PENDING with if1_ready=0 for 3 cycles, then if3_redir to 0x80003000: pc holds 3 cycles, then 0x80003000, FSM=RUN.
- Backend and IF3 redirects in the same cycle (0x9000 / 0xA000): next pc=0x9000. Async rst mid-stall: pc=BFC00000 and fetch_valid=0 immediately.
- pc=0x80000004, nlp_valid0/taken0 target 0x80004000: mask 10, DS_PENDING entered, next pc=0x80000008 with mask 01, then 0x80004000.
